// File: rtl/fft_pkg.sv
// Shared FFT types and fixed-point helpers (rounding, scaling, saturation).
// Helpers work on a wide signed accumulator so every FFT block can share them
// regardless of its own data and twiddle widths.
package fft_pkg;

    typedef enum logic {
        BFLY_DIT = 1'b0,
        BFLY_DIF = 1'b1
    } bfly_mode_e;

    // Per-sample control that travels alongside the data through the pipeline.
    typedef struct packed {
        logic       valid;
        bfly_mode_e mode;
        logic       scale;
    } bfly_ctl_t;

    localparam int unsigned ACC_W = 64;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Largest positive twiddle, Q1.(tw_w-1): 2^(tw_w-1)-1.
    function automatic acc_t tw_one(input int unsigned tw_w);
        return (acc_t'(1) <<< (tw_w - 1)) - acc_t'(1);
    endfunction

    // Exact -1.0 twiddle: -2^(tw_w-1).
    function automatic acc_t tw_minus_one(input int unsigned tw_w);
        return -(acc_t'(1) <<< (tw_w - 1));
    endfunction

    // Add half an LSB, then arithmetic shift: rounds half toward +inf.
    function automatic acc_t round_shr(input acc_t v, input int unsigned sh);
        if (sh == 0) begin
            return v;
        end
        return (v + (acc_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    // Optional divide-by-2 with the same half-up rounding.
    function automatic acc_t half_round(input acc_t v, input logic en);
        return en ? ((v + acc_t'(1)) >>> 1) : v;
    endfunction

    // Clamp to the signed range of a w-bit word.
    function automatic acc_t sat_clamp(input acc_t v, input int unsigned w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // High when sat_clamp would alter the value.
    function automatic logic sat_hit(input acc_t v, input int unsigned w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/cmult_rnd.sv
// Two-stage registered complex multiply with rounding.
//   Stage 1: registers the four partial products op*w.
//   Stage 2: forms re/im sums and rounds by TW_W-1 bits (Q1.(TW_W-1) twiddle).
// Ports:
//   clk, reset (async, active-high), enable (advance; 0 = hold)
//   op_re/op_im  signed OP_W operand
//   w_re/w_im    signed TW_W twiddle
//   p_re/p_im    signed OUT_W rounded product, registered
module cmult_rnd
    import fft_pkg::*;
#(
    parameter int unsigned OP_W  = 17,
    parameter int unsigned TW_W  = 16,
    parameter int unsigned OUT_W = OP_W + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [OP_W-1:0]  op_re,
    input  logic signed [OP_W-1:0]  op_im,
    input  logic signed [TW_W-1:0]  w_re,
    input  logic signed [TW_W-1:0]  w_im,
    output logic signed [OUT_W-1:0] p_re,
    output logic signed [OUT_W-1:0] p_im
);

    localparam int unsigned PP_W  = OP_W + TW_W;
    localparam int unsigned SUM_W = PP_W + 1;

    logic signed [PP_W-1:0]  pp_rr;
    logic signed [PP_W-1:0]  pp_ii;
    logic signed [PP_W-1:0]  pp_ri;
    logic signed [PP_W-1:0]  pp_ir;
    logic signed [SUM_W-1:0] sum_re_c;
    logic signed [SUM_W-1:0] sum_im_c;

    // Stage 1: full-precision partial products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pp_rr <= '0;
            pp_ii <= '0;
            pp_ri <= '0;
            pp_ir <= '0;
        end else if (enable) begin
            pp_rr <= PP_W'(op_re) * PP_W'(w_re);
            pp_ii <= PP_W'(op_im) * PP_W'(w_im);
            pp_ri <= PP_W'(op_re) * PP_W'(w_im);
            pp_ir <= PP_W'(op_im) * PP_W'(w_re);
        end
    end

    // One extra bit keeps the (-1)*(-1) corner from wrapping.
    always_comb begin
        sum_re_c = SUM_W'(pp_rr) - SUM_W'(pp_ii);
        sum_im_c = SUM_W'(pp_ri) + SUM_W'(pp_ir);
    end

    // Stage 2: round back to operand scale; the result always fits OUT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_re <= '0;
            p_im <= '0;
        end else if (enable) begin
            p_re <= OUT_W'(round_shr(acc_t'(sum_re_c), TW_W - 1));
            p_im <= OUT_W'(round_shr(acc_t'(sum_im_c), TW_W - 1));
        end
    end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 FFT butterfly with runtime twiddle, per-sample DIT/DIF,
// optional 1/2 scaling and saturation with a sticky overflow flag.
//   DIT: P = B*W, X = A+P, Y = A-P     DIF: X = A+B, Y = (A-B)*W
// Latency 3 enabled cycles, throughput 1 sample per enabled cycle.
// Ports:
//   clk, reset (async, active-high), enable (0 = whole pipeline holds)
//   in_valid, mode (0 DIT / 1 DIF), scale (1 = halve outputs), clr_ovf
//   a_r/a_i, b_r/b_i  signed DATA_W inputs; w_r/w_i signed TW_W twiddle
//   x_r/x_i, y_r/y_i  signed DATA_W outputs; out_valid; ovf (sticky)
module butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TW_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic                     mode,
    input  logic                     scale,
    input  logic                     clr_ovf,
    input  logic signed [DATA_W-1:0] a_r,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_r,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [TW_W-1:0]   w_r,
    input  logic signed [TW_W-1:0]   w_i,
    output logic signed [DATA_W-1:0] x_r,
    output logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] y_r,
    output logic signed [DATA_W-1:0] y_i,
    output logic                     out_valid,
    output logic                     ovf
);

    // Operands carry one growth bit for A+B / A-B; the product carries two more.
    localparam int unsigned OP_W = DATA_W + 1;
    localparam int unsigned P_W  = OP_W + 2;

    logic signed [OP_W-1:0]   a_re_x;
    logic signed [OP_W-1:0]   a_im_x;
    logic signed [OP_W-1:0]   b_re_x;
    logic signed [OP_W-1:0]   b_im_x;
    logic signed [OP_W-1:0]   op_re_c;
    logic signed [OP_W-1:0]   op_im_c;
    logic signed [OP_W-1:0]   pass_re_c;
    logic signed [OP_W-1:0]   pass_im_c;
    bfly_ctl_t                ctl_in_c;

    logic signed [OP_W-1:0]   pass1_re;
    logic signed [OP_W-1:0]   pass1_im;
    logic signed [OP_W-1:0]   pass2_re;
    logic signed [OP_W-1:0]   pass2_im;
    bfly_ctl_t                ctl1;
    bfly_ctl_t                ctl2;

    logic signed [P_W-1:0]    p_re;
    logic signed [P_W-1:0]    p_im;

    acc_t                     res_c [4];
    logic signed [DATA_W-1:0] sat_c [4];
    logic [3:0]               hit_c;
    logic                     ovf_set_c;

    // Operand mux: DIT multiplies B and passes A; DIF multiplies A-B and passes A+B.
    always_comb begin
        a_re_x    = OP_W'(a_r);
        a_im_x    = OP_W'(a_i);
        b_re_x    = OP_W'(b_r);
        b_im_x    = OP_W'(b_i);
        op_re_c   = b_re_x;
        op_im_c   = b_im_x;
        pass_re_c = a_re_x;
        pass_im_c = a_im_x;
        if (bfly_mode_e'(mode) == BFLY_DIF) begin
            op_re_c   = a_re_x - b_re_x;
            op_im_c   = a_im_x - b_im_x;
            pass_re_c = a_re_x + b_re_x;
            pass_im_c = a_im_x + b_im_x;
        end
        ctl_in_c.valid = in_valid;
        ctl_in_c.mode  = bfly_mode_e'(mode);
        ctl_in_c.scale = scale;
    end

    cmult_rnd #(
        .OP_W  (OP_W),
        .TW_W  (TW_W),
        .OUT_W (P_W)
    ) u_cmult (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .op_re  (op_re_c),
        .op_im  (op_im_c),
        .w_re   (w_r),
        .w_im   (w_i),
        .p_re   (p_re),
        .p_im   (p_im)
    );

    // Pass-through operand and control delayed to line up with the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass1_re <= '0;
            pass1_im <= '0;
            pass2_re <= '0;
            pass2_im <= '0;
            ctl1     <= '0;
            ctl2     <= '0;
        end else if (enable) begin
            pass1_re <= pass_re_c;
            pass1_im <= pass_im_c;
            pass2_re <= pass1_re;
            pass2_im <= pass1_im;
            ctl1     <= ctl_in_c;
            ctl2     <= ctl1;
        end
    end

    // Final add/sub, scale and saturate; index order is X.re, X.im, Y.re, Y.im.
    always_comb begin
        res_c[0] = acc_t'(pass2_re);
        res_c[1] = acc_t'(pass2_im);
        res_c[2] = acc_t'(p_re);
        res_c[3] = acc_t'(p_im);
        if (ctl2.mode == BFLY_DIT) begin
            res_c[0] = acc_t'(pass2_re) + acc_t'(p_re);
            res_c[1] = acc_t'(pass2_im) + acc_t'(p_im);
            res_c[2] = acc_t'(pass2_re) - acc_t'(p_re);
            res_c[3] = acc_t'(pass2_im) - acc_t'(p_im);
        end
        for (int k = 0; k < 4; k++) begin
            sat_c[k] = DATA_W'(sat_clamp(half_round(res_c[k], ctl2.scale), DATA_W));
            hit_c[k] = sat_hit(half_round(res_c[k], ctl2.scale), DATA_W);
        end
        // Only a valid sample actually leaving S3 may raise the flag.
        ovf_set_c = enable & ctl2.valid & (|hit_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r       <= '0;
            x_i       <= '0;
            y_r       <= '0;
            y_i       <= '0;
            out_valid <= 1'b0;
        end else if (enable) begin
            x_r       <= sat_c[0];
            x_i       <= sat_c[1];
            y_r       <= sat_c[2];
            y_i       <= sat_c[3];
            out_valid <= ctl2.valid;
        end
    end

    // Sticky flag; a new set beats a simultaneous clear, and clear ignores enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_set_c | (ovf & ~clr_ovf);
        end
    end

endmodule
